// File: rtl/minilab1_pkg.sv
// Shared constants and FSM state type for the Minilab1 matrix-vector loader.
// Sized for eight matrix rows plus the vector, one 64-bit memory word per FIFO.
package minilab1_pkg;

    localparam int NUM_FIFOS      = 9;
    localparam int BYTES_PER_WORD = 8;
    localparam int MEM_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FILL,
        DONE
    } loader_state_t;

endpackage

// File: rtl/word_serializer.sv
// Holds one memory word and presents its bytes MSB-first, one per advance.
// Zero latency from load to byte 0; the index only moves when i_advance is high.
module word_serializer
    import minilab1_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_load,
    input  logic [MEM_DATA_WIDTH-1:0] i_word,
    input  logic                      i_advance,
    output logic [7:0]                o_byte,
    output logic                      o_last
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [MEM_DATA_WIDTH-1:0] r_word;
    logic [IDX_W-1:0]          r_idx;
    logic [MEM_DATA_WIDTH-1:0] w_shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
        end else if (i_advance) begin
            r_idx  <= r_idx + IDX_W'(1);
        end
    end

    // Byte 0 lives in the top bits, so shift the selected byte up to the MSBs.
    assign w_shifted = r_word << {r_idx, 3'b000};
    assign o_byte    = w_shifted[MEM_DATA_WIDTH-1 -: 8];
    assign o_last    = (r_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/fifo_loader.sv
// Fetches NUM_ROWS+1 words over a single-outstanding read master and writes each, byte by byte, into its FIFO.
// One request per row, no pipelining; a full FIFO stalls the byte stream one cycle per full cycle.
module fifo_loader
    import minilab1_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_ROWS   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int BASE_ADDR  = 0
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    output logic                      mem_read,
    input  logic                      mem_waitrequest,
    input  logic [MEM_DATA_WIDTH-1:0] mem_readdata,
    input  logic                      mem_readdatavalid,
    output logic [NUM_ROWS:0]         wren,
    output logic [DATA_WIDTH-1:0]     wdata,
    input  logic [NUM_ROWS:0]         full
);

    localparam int NF    = NUM_ROWS + 1;
    localparam int ROW_W = $clog2(NF);

    if (DEPTH < BYTES_PER_WORD) begin : g_depth_chk
        $error("fifo_loader: DEPTH must hold a full row");
    end

    loader_state_t    r_state;
    logic [ROW_W-1:0] r_row;
    logic             r_done;

    logic             w_full_row;
    logic             w_advance;
    logic             w_load;
    logic             w_last;
    logic [7:0]       w_byte;

    assign w_full_row = full[r_row];
    assign w_advance  = (r_state == FILL) && !w_full_row;
    // Data arriving outside WAIT is not ours and must not disturb the held word.
    assign w_load     = (r_state == WAIT) && mem_readdatavalid;

    word_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_word    (mem_readdata),
        .i_advance (w_advance),
        .o_byte    (w_byte),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= REQ;
                        r_row   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) r_state <= WAIT;
                end
                WAIT: begin
                    if (mem_readdatavalid) r_state <= FILL;
                end
                FILL: begin
                    if (w_advance && w_last) begin
                        if (r_row == ROW_W'(NUM_ROWS)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_row   <= r_row + ROW_W'(1);
                            r_state <= REQ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state == REQ) || (r_state == WAIT) || (r_state == FILL);
    assign done        = r_done;
    assign mem_read    = (r_state == REQ);
    assign mem_address = mem_read ? (ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_row)) : '0;
    assign wren        = w_advance ? (NF'(1) << r_row) : '0;
    assign wdata       = (r_state == FILL) ? DATA_WIDTH'(w_byte) : '0;

endmodule

// File: tb/tb_fifo_loader.sv
// Directed bench for fifo_loader with a memory slave, FIFO-side capture and a byte-queue reference model.
module tb_fifo_loader;

    localparam int NR = 8;
    localparam int NF = NR + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [31:0]   mem_address;
    logic          mem_read;
    logic          mem_waitrequest;
    logic [63:0]   mem_readdata;
    logic          mem_readdatavalid;
    logic [NF-1:0] wren;
    logic [7:0]    wdata;
    logic [NF-1:0] full;

    fifo_loader #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .NUM_ROWS   (NR),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .wren              (wren),
        .wdata             (wdata),
        .full              (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] fifo;
        logic [7:0] dat;
    } ent_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    logic [63:0] mem [16];
    int          ws_cfg, lat_cfg, stall_fifo, stall_at, stall_rem;
    bit          spur_cfg;

    ent_t        exp_q[$];
    bit          exp_busy, exp_done, outstanding;
    int          req_row, rows_arrived;

    logic [7:0]  got [NF][16];
    int          got_cnt [NF];

    int          pend, ws_cnt, sp_cnt;
    logic [31:0] pend_addr;
    bit          prev_stall, prev_done, done_seen;
    logic [31:0] prev_addr;
    int          done_cyc, start_cyc;

    bit          avail, erd;
    logic [NF-1:0] ewren;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
        end
    endtask

    // Environment: memory slave and FIFO full flags driven on the falling edge,
    // outputs compared against the reference model shortly before the rising edge.
    initial begin
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        full              = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_readdatavalid = 1'b0;
            mem_readdata      = '0;
            mem_waitrequest   = 1'b0;
            if (rst_n) begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata      = mem[pend_addr[3:0]];
                        if (spur_cfg) sp_cnt = 3;
                    end
                end else if (sp_cnt > 0) begin
                    sp_cnt--;
                    if (sp_cnt == 0) begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
                    end
                end
                if (mem_read && ws_cnt < ws_cfg) begin
                    mem_waitrequest = 1'b1;
                    ws_cnt++;
                end
                for (int k = 0; k < NF; k++) full[k] = (got_cnt[k] >= 8);
                if (stall_rem > 0 && got_cnt[stall_fifo] == stall_at) begin
                    full[stall_fifo] = 1'b1;
                    stall_rem--;
                end
            end else begin
                full = '0;
            end
            #3;
            if (!rst_n) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_mem_read", mem_read, 0);
                chk("rst_mem_address", mem_address, 0);
                chk("rst_wren", wren, 0);
                chk("rst_wdata", wdata, 0);
                exp_busy = 0; exp_done = 0; outstanding = 0;
                req_row = 0; rows_arrived = 0; exp_q.delete();
                pend = 0; sp_cnt = 0; ws_cnt = 0;
                prev_stall = 0; prev_done = 0;
                for (int k = 0; k < NF; k++) got_cnt[k] = 0;
            end else begin
                avail = (exp_q.size() > 0) && (int'(exp_q[0].fifo) < rows_arrived);
                ewren = '0;
                if (avail && !full[exp_q[0].fifo]) ewren[exp_q[0].fifo] = 1'b1;
                erd = exp_busy && !outstanding && !avail && (req_row < NF);

                chk("busy", busy, exp_busy);
                chk("done", done, exp_done);
                chk("mem_read", mem_read, erd);
                chk("wren", wren, ewren);
                if (erd) chk("mem_address", mem_address, req_row);
                if (ewren != '0) chk("wdata", wdata, exp_q[0].dat);
                if (!exp_busy && !exp_done) begin
                    chk("idle_wdata", wdata, 0);
                    chk("idle_mem_address", mem_address, 0);
                end
                if (prev_stall) begin
                    chk("hold_mem_read", mem_read, 1);
                    chk("hold_mem_address", mem_address, prev_addr);
                end

                for (int k = 0; k < NF; k++) begin
                    if (wren[k] && got_cnt[k] < 16) begin
                        got[k][got_cnt[k]] = wdata;
                        got_cnt[k]++;
                    end
                end
                if (done && !prev_done) begin
                    done_cyc  = cyc;
                    done_seen = 1;
                end
                prev_done  = done;
                prev_stall = mem_read && mem_waitrequest;
                prev_addr  = mem_address;
                if (mem_read && !mem_waitrequest) begin
                    pend      = lat_cfg;
                    pend_addr = mem_address;
                    ws_cnt    = 0;
                end

                if (ewren != '0) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        exp_busy = 0;
                        exp_done = 1;
                    end
                end
                if (mem_readdatavalid && outstanding) begin
                    outstanding = 0;
                    rows_arrived++;
                end
                if (erd && !mem_waitrequest) begin
                    outstanding = 1;
                    req_row++;
                end
                if (start && !exp_busy) begin
                    exp_busy = 1; exp_done = 0; outstanding = 0;
                    req_row = 0; rows_arrived = 0; exp_q.delete();
                    for (int r = 0; r < NF; r++) begin
                        for (int b = 0; b < 8; b++) begin
                            ent_t e;
                            e.fifo = 4'(r);
                            e.dat  = 8'(mem[r] >> (8 * (7 - b)));
                            exp_q.push_back(e);
                        end
                    end
                    for (int k = 0; k < NF; k++) got_cnt[k] = 0;
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        done_seen = 0;
        @(negedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int exp_len, input string nm);
        int n = 0;
        while (!done_seen && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done_seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout, done never rose", nm);
        end else begin
            chk(nm, done_cyc - start_cyc, exp_len);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        ws_cfg = 0; lat_cfg = 1; spur_cfg = 0;
        stall_fifo = 0; stall_at = 0; stall_rem = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic load: word k is k replicated, done 91 cycles after start.
        for (int k = 0; k < NF; k++) mem[k] = {8{8'(k)}};
        do_start();
        wait_done(91, "basic_done_cycle");
        chk("basic_f3_b5", got[3][5], 8'h03);
        chk("basic_f8_b7", got[8][7], 8'h08);
        chk("basic_f8_count", got_cnt[8], 8);

        // Byte order, restart from DONE, stray readdatavalid, start while busy.
        mem[0] = 64'h0102_0304_0506_0708;
        for (int k = 1; k < NF; k++) mem[k] = {$urandom, $urandom};
        spur_cfg = 1;
        do_start();
        #3;
        chk("restart_done_cleared", done, 0);
        chk("restart_mem_read", mem_read, 1);
        chk("restart_base_addr", mem_address, 0);
        repeat (40) @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        wait_done(91, "order_done_cycle");
        for (int i = 0; i < 8; i++) chk("order_f0_byte", got[0][i], 8'(i + 1));
        spur_cfg = 0;

        // Waitrequest for 3 cycles and read latency 4: 16 cycles per row.
        ws_cfg = 3; lat_cfg = 4;
        for (int k = 0; k < NF; k++) mem[k] = {$urandom, $urandom};
        do_start();
        wait_done(145, "waitreq_done_cycle");
        ws_cfg = 0; lat_cfg = 1;

        // full[2] high for 5 cycles after the third byte of row 2.
        mem[2] = 64'h2021_2223_2425_2627;
        stall_fifo = 2; stall_at = 3; stall_rem = 5;
        do_start();
        wait_done(96, "stall_done_cycle");
        chk("stall_consumed", stall_rem, 0);
        chk("stall_f2_count", got_cnt[2], 8);
        chk("stall_f2_b3", got[2][3], 8'h23);
        chk("stall_f2_b4", got[2][4], 8'h24);

        // Asynchronous reset just before byte 4 of row 5.
        do_start();
        n = 0;
        while (got_cnt[5] != 4 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("arst_reached_row5_byte4", got_cnt[5], 4);
        chk("arst_pre_wren", wren, 9'b000100000);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_mem_read", mem_read, 0);
        chk("arst_mem_address", mem_address, 0);
        chk("arst_wren", wren, 0);
        chk("arst_wdata", wdata, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        mem[0] = 64'hA0A1_A2A3_A4A5_A6A7;
        do_start();
        wait_done(91, "post_reset_done_cycle");
        chk("post_reset_f0_b0", got[0][0], 8'hA0);
        chk("post_reset_f0_b7", got[0][7], 8'hA7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
